// File: rtl/stack_pkg.sv
// Shared constants for the operand stack: default sizes and operation encodings.
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_TOS  = 3'd3;
  localparam logic [2:0] OP_REPL = 3'd4;

  // push+pop collapses to a replace-top; tos loses to either push or pop
  function automatic logic [2:0] decode_op(input logic push, input logic pop, input logic tos);
    logic [2:0] op;
    if (push && pop)  op = OP_REPL;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
    else if (tos)     op = OP_TOS;
    else              op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand store: pointer/flag control, op decode and the registered d_out result.
module operand_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         d_out,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf_err,
  output logic                     unf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] SP_ONE  = (PW+1)'(1);
  localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

  logic [PW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [2:0]       op;
  logic [PW:0]      sp_m1;
  logic [PW-1:0]    top_idx;
  logic             we;
  logic [PW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_FULL);
  assign sp_m1   = sp_q - SP_ONE;
  assign top_idx = sp_m1[PW-1:0];

  always_comb begin
    op      = decode_op(push, pop, tos);
    sp_d    = sp_q;
    d_out_d = d_out_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    we      = 1'b0;
    waddr   = sp_q[PW-1:0];
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + SP_ONE;
        end
      end
      OP_POP: begin
        if (empty) begin
          d_out_d = '0;
          unf_d   = 1'b1;
        end else begin
          d_out_d = rdata;
          sp_d    = sp_m1;
        end
      end
      OP_TOS: begin
        if (empty) begin
          d_out_d = '0;
          unf_d   = 1'b1;
        end else begin
          d_out_d = rdata;
        end
      end
      OP_REPL: begin
        // An empty stack has no top to replace, so this degrades to a plain push
        if (empty) begin
          we    = 1'b1;
          sp_d  = sp_q + SP_ONE;
          unf_d = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = top_idx;
          d_out_d = rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      d_out_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // The write is gated by rst so a push coinciding with reset leaves the array untouched
  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_regfile (
    .clk   (clk),
    .we    (we & ~rst),
    .waddr (waddr),
    .wdata (d_in),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign d_out   = d_out_q;
  assign depth   = sp_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: directed ops queue expected state, a monitor checks it.
module tb_operand_stack;
  import stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic [4:0] depth;
  logic       empty, full, ovf_err, unf_err;

  operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .d_in(d_in),
    .err_clr(err_clr), .d_out(d_out), .depth(depth), .empty(empty), .full(full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         due;
    logic [7:0] d;
    logic [4:0] dep;
    logic       o;
    logic       u;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   op_cnt [5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      logic ok;
      e = exp_q.pop_front();
      n_chk++;
      ok = (d_out === e.d) && (depth === e.dep) && (empty === (e.dep == 5'd0)) &&
           (full === (e.dep == 5'd16)) && (ovf_err === e.o) && (unf_err === e.u);
      if (ok) n_pass++;
      else $display("FAIL %s: got d_out=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want d_out=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                    e.nm, d_out, depth, empty, full, ovf_err, unf_err,
                    e.d, e.dep, (e.dep == 5'd0), (e.dep == 5'd16), e.o, e.u);
    end
  end

  task automatic op(input string nm, input logic r, input logic ps, input logic pp,
                    input logic ts, input logic [7:0] din, input logic clr,
                    input logic [7:0] ed, input logic [4:0] edep, input logic eo,
                    input logic eu);
    exp_t e;
    @(posedge clk); #1;
    rst = r; push = ps; pop = pp; tos = ts; d_in = din; err_clr = clr;
    if (!r) op_cnt[decode_op(ps, pp, ts)]++;
    e.nm = nm; e.due = cyc + 1; e.d = ed; e.dep = edep; e.o = eo; e.u = eu;
    exp_q.push_back(e);
  endtask

  initial begin
    // reset
    op("reset",        1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    // scenario 1
    op("s1_push11",    0, 1, 0, 0, 8'h11, 0, 8'h00, 1, 0, 0);
    op("s1_push22",    0, 1, 0, 0, 8'h22, 0, 8'h00, 2, 0, 0);
    op("s1_push33",    0, 1, 0, 0, 8'h33, 0, 8'h00, 3, 0, 0);
    op("s1_tos",       0, 0, 0, 1, 8'h00, 0, 8'h33, 3, 0, 0);
    // scenario 2
    op("s2_pop1",      0, 0, 1, 0, 8'h00, 0, 8'h33, 2, 0, 0);
    op("s2_pop2",      0, 0, 1, 0, 8'h00, 0, 8'h22, 1, 0, 0);
    op("s2_pop3",      0, 0, 1, 0, 8'h00, 0, 8'h11, 0, 0, 0);
    // scenario 3: fill, overflow, error clear, set-wins-over-clear
    for (int i = 0; i < 16; i++)
      op($sformatf("s3_fill%0d", i), 0, 1, 0, 0, 8'(i), 0, 8'h11, 5'(i + 1), 0, 0);
    op("s3_push_full", 0, 1, 0, 0, 8'hAA, 0, 8'h11, 16, 1, 0);
    op("s3_pop_top",   0, 0, 1, 0, 8'h00, 0, 8'h0F, 15, 1, 0);
    op("s3_clr",       0, 0, 0, 0, 8'h00, 1, 8'h0F, 15, 0, 0);
    op("s3_refill",    0, 1, 0, 0, 8'hBB, 0, 8'h0F, 16, 0, 0);
    op("s3_ovf_clr",   0, 1, 0, 0, 8'hCC, 1, 8'h0F, 16, 1, 0);
    op("s3_clr2",      0, 0, 0, 0, 8'h00, 1, 8'h0F, 16, 0, 0);
    op("s3_tos_full",  0, 0, 0, 1, 8'h00, 0, 8'hBB, 16, 0, 0);
    op("s3_reset",     1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    // scenario 4: underflow
    op("s4_pop_empty", 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    op("s4_tos_empty", 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1);
    op("s4_push5a",    0, 1, 0, 0, 8'h5A, 0, 8'h00, 1, 0, 1);
    op("s4_tos",       0, 0, 0, 1, 8'h00, 0, 8'h5A, 1, 0, 1);
    op("s4_clr",       0, 0, 0, 0, 8'h00, 1, 8'h5A, 1, 0, 0);
    op("s4_pop",       0, 0, 1, 0, 8'h00, 0, 8'h5A, 0, 0, 0);
    // scenario 5: zero-check flow and hold while idle
    op("s5_push00",    0, 1, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 0);
    op("s5_tos00",     0, 0, 0, 1, 8'h00, 0, 8'h00, 1, 0, 0);
    op("s5_idle",      0, 0, 0, 0, 8'hEE, 0, 8'h00, 1, 0, 0);
    op("s5_push01",    0, 1, 0, 0, 8'h01, 0, 8'h00, 2, 0, 0);
    op("s5_tos01",     0, 0, 0, 1, 8'h00, 0, 8'h01, 2, 0, 0);
    op("s5_idle2",     0, 0, 0, 0, 8'h00, 0, 8'h01, 2, 0, 0);
    // scenario 6: simultaneous strobes, reset during push
    op("s6_reset",     1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    op("s6_push10",    0, 1, 0, 0, 8'h10, 0, 8'h00, 1, 0, 0);
    op("s6_push20",    0, 1, 0, 0, 8'h20, 0, 8'h00, 2, 0, 0);
    op("s6_replace",   0, 1, 1, 0, 8'h77, 0, 8'h20, 2, 0, 0);
    op("s6_tos77",     0, 0, 0, 1, 8'h00, 0, 8'h77, 2, 0, 0);
    op("s6_pop77",     0, 0, 1, 0, 8'h00, 0, 8'h77, 1, 0, 0);
    op("s6_tos10",     0, 0, 0, 1, 8'h00, 0, 8'h10, 1, 0, 0);
    op("s6_push_tos",  0, 1, 0, 1, 8'h99, 0, 8'h10, 2, 0, 0);
    op("s6_pop_tos",   0, 0, 1, 1, 8'h00, 0, 8'h99, 1, 0, 0);
    op("s6_pop10",     0, 0, 1, 0, 8'h00, 0, 8'h10, 0, 0, 0);
    op("s6_repl_empty",0, 1, 1, 0, 8'h44, 0, 8'h10, 1, 0, 1);
    op("s6_tos44",     0, 0, 0, 1, 8'h00, 0, 8'h44, 1, 0, 1);
    op("s6_rst_push",  1, 1, 0, 0, 8'hCC, 0, 8'h00, 0, 0, 0);
    op("s6_tos_after", 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1);

    @(posedge clk); #1;
    rst = 0; push = 0; pop = 0; tos = 0; d_in = 8'h00; err_clr = 0;
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      n_chk += exp_q.size();
    end
    $display("op mix: none=%0d push=%0d pop=%0d tos=%0d repl=%0d",
             op_cnt[OP_NONE], op_cnt[OP_PUSH], op_cnt[OP_POP], op_cnt[OP_TOS], op_cnt[OP_REPL]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
